// File: rtl/kgp_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package kgp_muldiv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned REG_W    = 5;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // MULHU and REMU read the upper/accumulator half; MUL and DIVU the shift register.
    function automatic logic is_acc_result(input op_e op);
        return (op == OP_MULHU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between the controller and muldiv_unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = kgp_muldiv_pkg::XLEN_DEF
) ();
    logic                                start;
    logic [1:0]                          op;
    logic [XLEN-1:0]                     src_a;
    logic [XLEN-1:0]                     src_b;
    logic [kgp_muldiv_pkg::REG_W-1:0]    dst;
    logic                                busy;
    logic                                done;
    logic                                wb_write;
    logic [kgp_muldiv_pkg::REG_W-1:0]    wb_dr;
    logic [XLEN-1:0]                     wb_data;

    modport master (
        output start, op, src_a, src_b, dst,
        input  busy, done, wb_write, wb_dr, wb_data
    );

    modport slave (
        input  start, op, src_a, src_b, dst,
        output busy, done, wb_write, wb_dr, wb_data
    );
endinterface

// File: rtl/muldiv_shift_core.sv
// One combinational radix-2 step: add-and-shift multiply or restoring divide.
module muldiv_shift_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] operand,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] mq,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] mq_nxt
);
    logic [XLEN:0] sum_c;
    logic [XLEN:0] shifted_c;
    logic [XLEN:0] diff_c;

    // Remainder stays below the divisor, so the sign of diff_c alone decides restore.
    always_comb begin
        sum_c     = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
        shifted_c = {acc, mq[XLEN-1]};
        diff_c    = shifted_c - {1'b0, operand};
        acc_nxt   = sum_c[XLEN:1];
        mq_nxt    = {sum_c[0], mq[XLEN-1:1]};
        if (is_div) begin
            if (!diff_c[XLEN]) begin
                acc_nxt = diff_c[XLEN-1:0];
                mq_nxt  = {mq[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = shifted_c[XLEN-1:0];
                mq_nxt  = {mq[XLEN-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/MULHU/DIVU/REMU unit with single-cycle register write-back.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero finish at accept.
module muldiv_unit
    import kgp_muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [REG_W-1:0]  dst_q, dst_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mq_q, mq_d;
    logic              busy_q, done_q, done_d, wb_write_q, wb_write_d;
    logic [REG_W-1:0]  wb_dr_q, wb_dr_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [XLEN-1:0]   step_acc, step_mq;
    op_e               op_in_c;
    logic              early_c;
    logic [XLEN-1:0]   early_data_c;

    assign op_in_c = op_e'(bus.op);

    muldiv_shift_core #(.XLEN(XLEN)) u_core (
        .is_div  (is_div_op(op_q)),
        .operand (opnd_q),
        .acc     (acc_q),
        .mq      (mq_q),
        .acc_nxt (step_acc),
        .mq_nxt  (step_mq)
    );

`ifdef MULDIV_EARLY_OUT_EN
    // Trivial results known at accept time.
    always_comb begin
        early_c      = 1'b0;
        early_data_c = '0;
        case (op_in_c)
            OP_MUL, OP_MULHU: early_c = (bus.src_a == '0) || (bus.src_b == '0);
            OP_DIVU: begin
                early_c      = (bus.src_b == '0);
                early_data_c = '1;
            end
            default: begin
                early_c      = (bus.src_b == '0);
                early_data_c = bus.src_a;
            end
        endcase
    end
`else
    assign early_c      = 1'b0;
    assign early_data_c = '0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        dst_d      = dst_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        done_d     = 1'b0;
        wb_write_d = 1'b0;
        wb_dr_d    = wb_dr_q;
        wb_data_d  = wb_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = op_in_c;
                    dst_d  = bus.dst;
                    cnt_d  = '0;
                    acc_d  = '0;
                    opnd_d = is_div_op(op_in_c) ? bus.src_b : bus.src_a;
                    mq_d   = is_div_op(op_in_c) ? bus.src_a : bus.src_b;
                    if (early_c) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        wb_write_d = (bus.dst != '0);
                        wb_dr_d    = bus.dst;
                        wb_data_d  = early_data_c;
                    end else begin
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (cnt_q == CNT_W'(XLEN)) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    wb_write_d = (dst_q != '0);
                    wb_dr_d    = dst_q;
                    wb_data_d  = is_acc_result(op_q) ? acc_q : mq_q;
                end else begin
                    acc_d = step_acc;
                    mq_d  = step_mq;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MUL;
            dst_q      <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wb_write_q <= 1'b0;
            wb_dr_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            dst_q      <= dst_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= done_d;
            wb_write_q <= wb_write_d;
            wb_dr_q    <= wb_dr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wb_write = wb_write_q;
    assign bus.wb_dr    = wb_dr_q;
    assign bus.wb_data  = wb_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;
    import kgp_muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    int   n_wb     = 0;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.done)     n_done++;
        if (bus.wb_write) n_wb++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (op[1] ? (b == 32'd0) : (a == 32'd0 || b == 32'd0)) return 0;
`endif
        return 33;
    endfunction

    // Issue one op; lat counts clock edges after the accept edge until done is seen.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input bit spam, input string tag);
        logic [31:0] exp_data;
        int lat, exp_lat, done0, wb0;
        exp_data = ref_result(op, a, b);
        exp_lat  = ref_latency(op, a, b);
        done0    = n_done;
        wb0      = n_wb;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.dst   = d;
        @(posedge clk); #1;
        bus.start = spam;
        lat = 0;
        while (!bus.done && lat < 100) begin
            if (spam) begin
                bus.src_a = $urandom();
                bus.src_b = $urandom();
                bus.dst   = 5'($urandom());
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_busy"}, 64'(bus.busy), 64'(1));
        check_eq({tag, "_wb_write"}, 64'(bus.wb_write), 64'(d != 5'd0));
        if (d != 5'd0) begin
            check_eq({tag, "_wb_dr"}, 64'(bus.wb_dr), 64'(d));
            check_eq({tag, "_wb_data"}, 64'(bus.wb_data), 64'(exp_data));
        end
        @(posedge clk); #1;
        check_eq({tag, "_done_drop"}, 64'({bus.done, bus.wb_write, bus.busy}), 64'(0));
        check_eq({tag, "_done_count"}, 64'(n_done - done0), 64'(1));
        check_eq({tag, "_wb_count"}, 64'(n_wb - wb0), 64'(d != 5'd0));
    endtask

    initial begin
        int done0, wb0;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rd;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.dst   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs",
                 64'({bus.busy, bus.done, bus.wb_write, bus.wb_dr}), 64'(0));
        check_eq("reset_wb_data", 64'(bus.wb_data), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        run_op(OP_MUL,   32'd7,         32'd6,         5'd5,  1'b0, "mul_7x6");
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  1'b0, "mulhu_max");
        run_op(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  1'b0, "mul_max");
        run_op(OP_DIVU,  32'd100,       32'd7,         5'd3,  1'b0, "divu_100_7");
        run_op(OP_REMU,  32'd100,       32'd7,         5'd4,  1'b0, "remu_100_7");
        run_op(OP_DIVU,  32'd5,         32'd0,         5'd6,  1'b0, "divu_by0");
        run_op(OP_REMU,  32'd5,         32'd0,         5'd7,  1'b0, "remu_by0");
        run_op(OP_MUL,   32'd0,         32'd1234,      5'd8,  1'b0, "mul_zero");
        run_op(OP_DIVU,  32'hDEAD_BEEF, 32'd3,         5'd9,  1'b1, "divu_spam");
        run_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd31, 1'b1, "mulhu_spam");
        run_op(OP_MUL,   32'd3,         32'd3,         5'd0,  1'b0, "mul_dst0");

        // Reset in the middle of an iteration abandons the write-back.
        done0 = n_done;
        wb0   = n_wb;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.src_a = 32'd11;
        bus.src_b = 32'd13;
        bus.dst   = 5'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("midreset_outputs", 64'({bus.busy, bus.done, bus.wb_write}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_eq("midreset_no_done", 64'(n_done - done0), 64'(0));
        check_eq("midreset_no_wb", 64'(n_wb - wb0), 64'(0));
        run_op(OP_REMU, 32'd1000, 32'd33, 5'd12, 1'b0, "after_reset");

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom());
            case ($urandom_range(0, 5))
                0:       ra = 32'd0;
                1:       ra = 32'hFFFF_FFFF;
                2:       ra = 32'($urandom_range(0, 255));
                default: ra = $urandom();
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom() >> $urandom_range(0, 31);
            endcase
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom());
            run_op(rop, ra, rb, rd, 1'($urandom()), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
